// File: rtl/xoodyak_seq_if.sv
// xoodyak_seq_if -- request and core-control bundle of the Xoodyak session sequencer.
//   req_valid/req_ready     request handshake (accept when both high)
//   req_dec                 0 = encrypt, 1 = decrypt
//   req_ad_blks/txt_blks    block counts of the session
//   core_start              one-cycle launch pulse to the permutation core
//   core_opmode             operation selector held while the core runs
//   core_blk_idx            block index within the current phase
//   core_finished           completion pulse from the core
// master: requester/core side, slave: the sequencer.
interface xoodyak_seq_if #(
  parameter int BLKW = 6
);
  logic            req_valid;
  logic            req_ready;
  logic            req_dec;
  logic [BLKW-1:0] req_ad_blks;
  logic [BLKW-1:0] req_txt_blks;
  logic            core_start;
  logic [3:0]      core_opmode;
  logic [BLKW-1:0] core_blk_idx;
  logic            core_finished;

  modport master (
    output req_valid, req_dec, req_ad_blks, req_txt_blks, core_finished,
    input  req_ready, core_start, core_opmode, core_blk_idx
  );

  modport slave (
    input  req_valid, req_dec, req_ad_blks, req_txt_blks, core_finished,
    output req_ready, core_start, core_opmode, core_blk_idx
  );
endinterface

// File: rtl/xoodyak_seq.sv
// xoodyak_seq -- sequences one Xoodyak AEAD session over a permutation core.
// Ports:
//   eph1      clock
//   reset_n   async active-low reset, release synchronised to eph1
//   bus       xoodyak_seq_if.slave: request handshake and core control
//   abort     synchronous session abort
//   sess_done one-cycle pulse on normal session end
//   sess_err  one-cycle pulse on abort or watchdog timeout
//   busy      high whenever not IDLE
// Build option: define XOODYAK_SEQ_RATCHET_EN to insert a ratchet operation
// between associated-data absorption and the text phase.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// INIT    | one init operation
// NONCE   | one nonce absorb
// ASSOC   | max(ad,1) associated-data absorbs
// RATCHET | one ratchet (only with XOODYAK_SEQ_RATCHET_EN)
// TEXT    | txt encrypt/decrypt blocks, skipped when txt=0
// SQZ     | one tag squeeze
// FIN     | one cycle, sess_done pulse
// Every operation state runs an ISSUE cycle (wait_q=0, core_start) then WAIT.
module xoodyak_seq #(
  parameter int BLKW = 6,
  parameter int TMO  = 255
) (
  input  logic         eph1,
  input  logic         reset_n,
  xoodyak_seq_if.slave bus,
  input  logic         abort,
  output logic         sess_done,
  output logic         sess_err,
  output logic         busy
);
  localparam int WDW = $clog2(TMO + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);
  localparam logic [BLKW:0]  IDX_ONE = (BLKW + 1)'(1);

  localparam logic [3:0] OP_IDLE = 4'd0, OP_INIT = 4'd1, OP_NONCE = 4'd2,
                         OP_ASSOC = 4'd3, OP_ENC = 4'd4, OP_DEC = 4'd5,
                         OP_SQZ = 4'd6, OP_RATCHET = 4'd7;

  typedef enum logic [2:0] {
    IDLE, INIT, NONCE, ASSOC,
`ifdef XOODYAK_SEQ_RATCHET_EN
    RATCHET,
`endif
    TEXT, SQZ, FIN
  } state_t;

  function automatic logic [3:0] op_of(input state_t s, input logic dec);
    case (s)
      INIT:    op_of = OP_INIT;
      NONCE:   op_of = OP_NONCE;
      ASSOC:   op_of = OP_ASSOC;
`ifdef XOODYAK_SEQ_RATCHET_EN
      RATCHET: op_of = OP_RATCHET;
`endif
      TEXT:    op_of = dec ? OP_DEC : OP_ENC;
      SQZ:     op_of = OP_SQZ;
      default: op_of = OP_IDLE;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s, input logic [BLKW-1:0] txt);
    case (s)
      INIT:    next_phase = NONCE;
      NONCE:   next_phase = ASSOC;
`ifdef XOODYAK_SEQ_RATCHET_EN
      ASSOC:   next_phase = RATCHET;
      RATCHET: next_phase = (txt == '0) ? SQZ : TEXT;
`else
      ASSOC:   next_phase = (txt == '0) ? SQZ : TEXT;
`endif
      TEXT:    next_phase = SQZ;
      default: next_phase = FIN;
    endcase
  endfunction

  // Release of reset takes effect one edge late so the FSM never sees a
  // partial-cycle deassertion.
  logic rst_sync_q;
  always_ff @(posedge eph1 or negedge reset_n)
    if (!reset_n) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;

  state_t          st_q, st_d;
  logic            wait_q, wait_d;
  logic [BLKW-1:0] idx_q, idx_d, ad_q, ad_d, txt_q, txt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            dec_q, dec_d;
  logic [3:0]      op_q, op_d;
  logic            start_q, start_d, done_q, done_d, err_q, err_d;
  logic            ready_q, ready_d, busy_q, busy_d;
  logic [BLKW:0]   idx_inc;
  logic            blk_last;

  always_comb begin
    st_d    = st_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    dec_d   = dec_q;
    ad_d    = ad_q;
    txt_d   = txt_q;
    op_d    = op_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // One extra bit so a count of 2^BLKW-1 terminates without wrapping.
    idx_inc = {1'b0, idx_q} + IDX_ONE;
    case (st_q)
      ASSOC:   blk_last = idx_inc >= {1'b0, ad_q};   // ad=0 still absorbs once
      TEXT:    blk_last = idx_inc >= {1'b0, txt_q};
      default: blk_last = 1'b1;
    endcase

    case (st_q)
      IDLE: if (bus.req_valid) begin
        dec_d   = bus.req_dec;
        ad_d    = bus.req_ad_blks;
        txt_d   = bus.req_txt_blks;
        st_d    = INIT;
        wait_d  = 1'b0;
        idx_d   = '0;
        wd_d    = '0;
        op_d    = OP_INIT;
        start_d = 1'b1;
      end
      // The session has already reported done; abort no longer applies.
      FIN: st_d = IDLE;
      default: begin
        if (abort || (wait_q && wd_q == WD_LAST)) begin
          st_d   = IDLE;
          wait_d = 1'b0;
          idx_d  = '0;
          wd_d   = '0;
          op_d   = OP_IDLE;
          err_d  = 1'b1;
        end else if (!wait_q) begin
          // ISSUE cycle: a finished pulse here belongs to no operation.
          wait_d = 1'b1;
          wd_d   = WDW'(1);
        end else if (bus.core_finished) begin
          wait_d = 1'b0;
          wd_d   = '0;
          if (!blk_last) begin
            idx_d   = idx_inc[BLKW-1:0];
            start_d = 1'b1;
          end else begin
            idx_d = '0;
            st_d  = next_phase(st_q, txt_q);
            op_d  = op_of(st_d, dec_q);
            if (st_d == FIN) done_d  = 1'b1;
            else             start_d = 1'b1;
          end
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
    endcase

    ready_d = (st_d == IDLE);
    busy_d  = (st_d != IDLE);
  end

  always_ff @(posedge eph1 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      st_q    <= IDLE;
      wait_q  <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      dec_q   <= 1'b0;
      ad_q    <= '0;
      txt_q   <= '0;
      op_q    <= OP_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      dec_q   <= dec_d;
      ad_q    <= ad_d;
      txt_q   <= txt_d;
      op_q    <= op_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.core_start   = start_q;
  assign bus.core_opmode  = op_q;
  assign bus.core_blk_idx = idx_q;
  assign sess_done        = done_q;
  assign sess_err         = err_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_xoodyak_seq.sv
// Bench for xoodyak_seq: a core model answers each core_start after a set
// latency; expected (opmode, block index) pairs are queued per request and
// checked against each start pulse.
module tb_xoodyak_seq;
  localparam int BLKW = 6;

  logic eph1 = 1'b0;
  logic reset_n = 1'b0;
  logic abort = 1'b0;
  logic sess_done, sess_err, busy;

  xoodyak_seq_if #(.BLKW(BLKW)) bus ();

  xoodyak_seq #(.BLKW(BLKW), .TMO(255)) dut (
    .eph1      (eph1),
    .reset_n   (reset_n),
    .bus       (bus),
    .abort     (abort),
    .sess_done (sess_done),
    .sess_err  (sess_err),
    .busy      (busy)
  );

  always #5 eph1 = ~eph1;

  typedef struct packed {
    logic [3:0]      op;
    logic [BLKW-1:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0, n_err = 0;
  int         cyc = 0;
  int         core_lat = 1;
  int         fin_cnt = 0;
  bit         fin_on_start = 1'b0;
  bit         force_fin = 1'b0;
  logic [3:0] hang_op = 4'd0;
  int         done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, nonce_cyc = 0;

  always @(posedge eph1) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge eph1);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input int idx);
    exp_t e;
    e.op  = op;
    e.idx = BLKW'(idx);
    exp_q.push_back(e);
  endtask

  task automatic push_ops(input bit dec, input int ad, input int txt);
    push(4'd1, 0);
    push(4'd2, 0);
    for (int i = 0; i < ((ad == 0) ? 1 : ad); i++) push(4'd3, i);
`ifdef XOODYAK_SEQ_RATCHET_EN
    push(4'd7, 0);
`endif
    for (int i = 0; i < txt; i++) push(dec ? 4'd5 : 4'd4, i);
    push(4'd6, 0);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ready"}, int'(bus.req_ready), 1);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_start"}, int'(bus.core_start), 0);
    check_val({tag, "_done"}, int'(sess_done), 0);
    check_val({tag, "_err"}, int'(sess_err), 0);
    check_val({tag, "_opmode"}, int'(bus.core_opmode), 0);
    check_val({tag, "_blk_idx"}, int'(bus.core_blk_idx), 0);
  endtask

  task automatic drive_req(input bit dec, input int ad, input int txt);
    bus.req_valid    = 1'b1;
    bus.req_dec      = dec;
    bus.req_ad_blks  = BLKW'(ad);
    bus.req_txt_blks = BLKW'(txt);
  endtask

  // Later changes of the request fields must not reach the running session.
  task automatic scramble_req();
    bus.req_valid    = 1'b0;
    bus.req_dec      = ~bus.req_dec;
    bus.req_ad_blks  = '1;
    bus.req_txt_blks = '1;
  endtask

  task automatic run_sess(input bit dec, input int ad, input int txt, input int lat,
                          input string tag);
    int d0, e0, n_ops, acc, k;
    core_lat = lat;
    exp_q.delete();
    push_ops(dec, ad, txt);
    n_ops = exp_q.size();
    d0 = done_cnt;
    e0 = err_cnt;
    check_val({tag, "_ready"}, int'(bus.req_ready), 1);
    drive_req(dec, ad, txt);
    acc = cyc;
    tick();
    scramble_req();
    check_val({tag, "_busy"}, int'(busy), 1);
    check_val({tag, "_ready_low"}, int'(bus.req_ready), 0);
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 3000) begin
      tick();
      k++;
    end
    check_val({tag, "_done"}, done_cnt - d0, 1);
    check_val({tag, "_err"}, err_cnt - e0, 0);
    // Cycles from the accept cycle through the sess_done cycle, both counted.
    check_val({tag, "_latency"}, done_cyc - acc + 1, n_ops * (lat + 1) + 2);
    check_val({tag, "_ops_left"}, exp_q.size(), 0);
    tick();
    check_val({tag, "_idle_busy"}, int'(busy), 0);
    check_val({tag, "_idle_ready"}, int'(bus.req_ready), 1);
    exp_q.delete();
  endtask

  // Core model and output monitor.
  initial begin
    exp_t e;
    int   n;
    bus.core_finished = 1'b0;
    forever begin
      @(negedge eph1);
      bus.core_finished = 1'b0;
      if (!reset_n) fin_cnt = 0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) bus.core_finished = 1'b1;
      end
      if (force_fin) begin
        bus.core_finished = 1'b1;
        force_fin = 1'b0;
      end
      if (sess_done) begin done_cnt++; done_cyc = cyc; end
      if (sess_err)  begin err_cnt++;  err_cyc = cyc;  end
      if (bus.core_start) begin
        if (bus.core_opmode == 4'd2) nonce_cyc = cyc;
        n = exp_q.size();
        check_val("start_expected", int'(n != 0), 1);
        if (n != 0) begin
          e = exp_q.pop_front();
          check_val("opmode", int'(bus.core_opmode), int'(e.op));
          check_val("blk_idx", int'(bus.core_blk_idx), int'(e.idx));
        end
        if (bus.core_opmode != hang_op) fin_cnt = core_lat;
        if (fin_on_start) bus.core_finished = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int d0, e0, k, rel, acc, n_ops;
    bus.req_valid    = 1'b0;
    bus.req_dec      = 1'b0;
    bus.req_ad_blks  = '0;
    bus.req_txt_blks = '0;
    repeat (3) tick();
    check_reset("por");
    reset_n = 1'b1;
    repeat (3) tick();

    run_sess(1'b0, 2, 3, 4, "enc_a2_t3");
    run_sess(1'b1, 0, 0, 2, "dec_a0_t0");
    run_sess(1'b0, 1, 1, 1, "enc_a1_t1");
    fin_on_start = 1'b1;
    run_sess(1'b1, 1, 2, 3, "fin_on_start");
    fin_on_start = 1'b0;
    run_sess(1'b0, 63, 1, 1, "ad_max");
    run_sess(1'b1, 2, 63, 1, "txt_max");

    // Abort on the second WAIT cycle of the first TEXT block.
    core_lat = 4;
    exp_q.delete();
    push_ops(1'b0, 1, 3);
    d0 = done_cnt;
    e0 = err_cnt;
    drive_req(1'b0, 1, 3);
    tick();
    scramble_req();
    k = 0;
    while (!(bus.core_start && bus.core_opmode == 4'd4) && k < 200) begin
      tick();
      k++;
    end
    check_val("abort_text_start", int'(bus.core_opmode), 4);
    tick();
    tick();
    abort = 1'b1;
    exp_q.delete();
    check_val("abort_busy_before", int'(busy), 1);
    tick();
    abort = 1'b0;
    check_val("abort_err", int'(sess_err), 1);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_ready", int'(bus.req_ready), 1);
    check_val("abort_opmode", int'(bus.core_opmode), 0);
    force_fin = 1'b1;
    repeat (10) tick();
    check_val("abort_err_count", err_cnt - e0, 1);
    check_val("abort_no_done", done_cnt - d0, 0);
    check_val("abort_spurious_busy", int'(busy), 0);

    // Abort while idle changes nothing.
    e0 = err_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check_val("idle_abort_err", err_cnt - e0, 0);
    check_val("idle_abort_busy", int'(busy), 0);

    // Watchdog: NONCE never finishes.
    hang_op  = 4'd2;
    core_lat = 2;
    exp_q.delete();
    push(4'd1, 0);
    push(4'd2, 0);
    d0 = done_cnt;
    e0 = err_cnt;
    drive_req(1'b0, 2, 2);
    tick();
    scramble_req();
    k = 0;
    while (err_cnt == e0 && k < 600) begin
      tick();
      k++;
    end
    check_val("wdog_err", err_cnt - e0, 1);
    check_val("wdog_no_done", done_cnt - d0, 0);
    check_val("wdog_delay", err_cyc - nonce_cyc, 255);
    check_val("wdog_ops_left", exp_q.size(), 0);
    tick();
    check_val("wdog_idle", int'(busy), 0);
    hang_op = 4'd0;

    // Reset in the middle of ASSOC.
    core_lat = 3;
    exp_q.delete();
    push_ops(1'b0, 5, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    drive_req(1'b0, 5, 1);
    tick();
    scramble_req();
    k = 0;
    while (!(bus.core_start && bus.core_opmode == 4'd3 && bus.core_blk_idx == 1) && k < 200) begin
      tick();
      k++;
    end
    check_val("rst_assoc_seen", int'(bus.core_blk_idx), 1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("rst_mid");
    repeat (3) tick();
    check_val("rst_no_done", done_cnt - d0, 0);
    check_val("rst_no_err", err_cnt - e0, 0);

    // Request held across reset release: accepted on the second edge.
    core_lat = 2;
    push_ops(1'b1, 1, 2);
    n_ops = exp_q.size();
    d0 = done_cnt;
    reset_n = 1'b1;
    drive_req(1'b1, 1, 2);
    rel = cyc;
    k = 0;
    while (!bus.core_start && k < 10) begin
      tick();
      k++;
    end
    check_val("release_first_start", cyc - rel, 2);
    scramble_req();
    acc = rel + 1;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      tick();
      k++;
    end
    check_val("restart_done", done_cnt - d0, 1);
    check_val("restart_latency", done_cyc - acc + 1, n_ops * (2 + 1) + 2);
    check_val("restart_ops_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
